// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALU control bit map, operand selects.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Bit positions inside the one-hot alu_ctrl vector; the ALU lanes use the same order.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLL  = 2;
  localparam int ALU_SLT  = 3;
  localparam int ALU_SLTU = 4;
  localparam int ALU_XOR  = 5;
  localparam int ALU_SRL  = 6;
  localparam int ALU_SRA  = 7;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 9;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  // One-hot vector with a single lane set.
  function automatic logic [CTRL_W-1:0] alu_lane(input int idx);
    logic [CTRL_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Register/register and register/immediate ALU ops share a funct3 map; only
  // OP honours funct7_5 on funct3 000 (SUB), both honour it on 101 (SRA).
  function automatic logic [CTRL_W-1:0] arith_lane(input logic [2:0] funct3,
                                                   input logic       funct7_5,
                                                   input logic       allow_sub);
    logic [CTRL_W-1:0] v;
    unique case (funct3)
      3'b000:  v = (allow_sub && funct7_5) ? alu_lane(ALU_SUB) : alu_lane(ALU_ADD);
      3'b001:  v = alu_lane(ALU_SLL);
      3'b010:  v = alu_lane(ALU_SLT);
      3'b011:  v = alu_lane(ALU_SLTU);
      3'b100:  v = alu_lane(ALU_XOR);
      3'b101:  v = funct7_5 ? alu_lane(ALU_SRA) : alu_lane(ALU_SRL);
      3'b110:  v = alu_lane(ALU_OR);
      default: v = alu_lane(ALU_AND);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control, writeback
// enable, illegal flag and operand selects.
module alu_ctrl_dec
  import riscv_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              reg_write,
  output logic              illegal,
  output a_sel_e            a_sel,
  output b_sel_e            b_sel
);

  // Opcode class decides operands and writeback; funct3 only matters for OP/OP-IMM/BRANCH.
  always_comb begin
    alu_ctrl  = '0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    a_sel     = A_SEL_RS1;
    b_sel     = B_SEL_IMM;
    unique case (opcode)
      OPC_OP: begin
        alu_ctrl  = arith_lane(funct3, funct7_5, 1'b1);
        reg_write = 1'b1;
        b_sel     = B_SEL_RS2;
      end
      OPC_OP_IMM: begin
        alu_ctrl  = arith_lane(funct3, funct7_5, 1'b0);
        reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        b_sel = B_SEL_RS2;
        unique case (funct3)
          3'b000, 3'b001: alu_ctrl = alu_lane(ALU_SUB);
          3'b100, 3'b101: alu_ctrl = alu_lane(ALU_SLT);
          3'b110, 3'b111: alu_ctrl = alu_lane(ALU_SLTU);
          default:        illegal  = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        alu_ctrl  = alu_lane(ALU_ADD);
        reg_write = 1'b1;
      end
      OPC_STORE: begin
        alu_ctrl = alu_lane(ALU_ADD);
      end
      OPC_JAL, OPC_AUIPC: begin
        alu_ctrl  = alu_lane(ALU_ADD);
        reg_write = 1'b1;
        a_sel     = A_SEL_PC;
      end
      OPC_LUI: begin
        alu_ctrl  = alu_lane(ALU_ADD);
        reg_write = 1'b1;
        a_sel     = A_SEL_ZERO;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, muxes operands and holds the
// EX slot with stall (hold) and flush (bubble) control.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic              ex_reg_write,
  output logic              ex_illegal
);

  logic [CTRL_W-1:0] dec_alu_ctrl;
  logic              dec_reg_write;
  logic              dec_illegal;
  a_sel_e            dec_a_sel;
  b_sel_e            dec_b_sel;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              wr_en;

  alu_ctrl_dec u_dec (
    .opcode    (id_opcode),
    .funct3    (id_funct3),
    .funct7_5  (id_funct7_5),
    .alu_ctrl  (dec_alu_ctrl),
    .reg_write (dec_reg_write),
    .illegal   (dec_illegal),
    .a_sel     (dec_a_sel),
    .b_sel     (dec_b_sel)
  );

  // Operand selection; writes to x0 are suppressed here so EX never has to look at rd.
  always_comb begin
    unique case (dec_a_sel)
      A_SEL_PC:   op_a = id_pc;
      A_SEL_ZERO: op_a = '0;
      default:    op_a = id_rs1_data;
    endcase
    op_b  = (dec_b_sel == B_SEL_RS2) ? id_rs2_data : id_imm;
    wr_en = dec_reg_write && (id_rd_addr != 5'd0);
  end

  // EX slot: flush beats stall; a non-valid ID slot is captured as an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_rs2_data  <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_alu_ctrl  <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_rs2_data  <= '0;
      ex_rs1_addr  <= '0;
      ex_rs2_addr  <= '0;
      ex_rd_addr   <= '0;
      ex_alu_ctrl  <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_a         <= op_a;
      ex_b         <= op_b;
      ex_rs2_data  <= id_rs2_data;
      ex_rs1_addr  <= id_rs1_addr;
      ex_rs2_addr  <= id_rs2_addr;
      ex_rd_addr   <= id_rd_addr;
      ex_alu_ctrl  <= dec_alu_ctrl;
      ex_reg_write <= wr_en;
      ex_illegal   <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a table-driven reference model of the EX slot.
module tb_id_ex_stage;

  logic        clk, rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic        stall, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_a, ex_b, ex_rs2_data;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [9:0]  ex_alu_ctrl;
  logic        ex_reg_write, ex_illegal;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b, rs2;
    logic [4:0]  r1, r2, rd;
    logic [9:0]  ctrl;
    logic        rw, ill;
  } ex_t;

  ex_t exp_ex;
  ex_t saved;

  // ALU code number (bit index) for each funct3 of OP/OP-IMM, before funct7_5 adjustment.
  int base_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] op_list[10] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F};

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rs2_data(ex_rs2_data),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what a valid instruction on the ID inputs should become in EX.
  function automatic ex_t model_capture();
    ex_t e;
    int  code;
    logic writes, is_legal;
    code     = -1;
    writes   = 1'b0;
    is_legal = 1'b1;
    e        = '0;
    e.v   = 1'b1;
    e.pc  = id_pc;
    e.rs2 = id_rs2_data;
    e.r1  = id_rs1_addr;
    e.r2  = id_rs2_addr;
    e.rd  = id_rd_addr;
    e.a   = id_rs1_data;
    e.b   = id_imm;
    case (id_opcode)
      7'h33: begin
        code = base_tab[id_funct3];
        if (id_funct7_5 && (id_funct3 == 3'd0 || id_funct3 == 3'd5)) code = code + 1;
        e.b = id_rs2_data; writes = 1'b1;
      end
      7'h13: begin
        code = base_tab[id_funct3];
        if (id_funct7_5 && id_funct3 == 3'd5) code = code + 1;
        writes = 1'b1;
      end
      7'h63: begin
        e.b = id_rs2_data;
        if (id_funct3 <= 3'd1)      code = 1;
        else if (id_funct3 <= 3'd3) is_legal = 1'b0;
        else if (id_funct3 <= 3'd5) code = 3;
        else                        code = 4;
      end
      7'h03, 7'h67: begin code = 0; writes = 1'b1; end
      7'h23:        begin code = 0; end
      7'h6F, 7'h17: begin code = 0; writes = 1'b1; e.a = id_pc; end
      7'h37:        begin code = 0; writes = 1'b1; e.a = 32'd0; end
      default:      is_legal = 1'b0;
    endcase
    e.ctrl = (code >= 0) ? (10'd1 << code) : 10'd0;
    e.rw   = writes && is_legal && (id_rd_addr != 5'd0);
    e.ill  = !is_legal;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(exp_ex.v));
    chk({tag, ".pc"}, ex_pc, exp_ex.pc);
    chk({tag, ".a"}, ex_a, exp_ex.a);
    chk({tag, ".b"}, ex_b, exp_ex.b);
    chk({tag, ".rs2"}, ex_rs2_data, exp_ex.rs2);
    chk({tag, ".rs1_addr"}, 32'(ex_rs1_addr), 32'(exp_ex.r1));
    chk({tag, ".rs2_addr"}, 32'(ex_rs2_addr), 32'(exp_ex.r2));
    chk({tag, ".rd_addr"}, 32'(ex_rd_addr), 32'(exp_ex.rd));
    chk({tag, ".alu_ctrl"}, 32'(ex_alu_ctrl), 32'(exp_ex.ctrl));
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(exp_ex.rw));
    chk({tag, ".illegal"}, 32'(ex_illegal), 32'(exp_ex.ill));
    chk({tag, ".onehot0"}, 32'($onehot0(ex_alu_ctrl)), 32'd1);
  endtask

  // Advance one edge, update the model with the same rules, check 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst || flush)   exp_ex = '0;
    else if (!stall)    exp_ex = id_valid ? model_capture() : '0;
    #1;
    check_all(tag);
  endtask

  task automatic rand_data();
    id_pc       = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_rs1_addr = 5'($urandom_range(0, 31));
    id_rs2_addr = 5'($urandom_range(0, 31));
    id_rd_addr  = 5'($urandom_range(1, 31));
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    id_opcode   = opc;
    id_funct3   = f3;
    id_funct7_5 = f7;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    rand_data();
    set_instr(7'h33, 3'd0, 1'b0);
    exp_ex = '0;
    #2;
    check_all("por");
    @(negedge clk); rst = 1'b0;

    // Reset asserted mid-cycle with valid data held clears everything immediately.
    id_valid = 1'b1;
    cycle("load_pre_rst");
    @(negedge clk); rst = 1'b1; #1;
    exp_ex = '0;
    check_all("async_rst");
    cycle("in_rst");
    @(negedge clk); rst = 1'b0; id_valid = 1'b0;
    cycle("post_rst_bubble");
    chk("post_rst_valid", 32'(ex_valid), 32'd0);

    // OP sweep over every funct3 and funct7_5.
    id_valid = 1'b1;
    for (int f3 = 0; f3 < 8; f3++) begin
      for (int f7 = 0; f7 < 2; f7++) begin
        @(negedge clk);
        rand_data();
        set_instr(7'h33, 3'(f3), 1'(f7));
        cycle("op_sweep");
        if (f3 == 5 && f7 == 1) chk("op_sra_code", 32'(ex_alu_ctrl), 32'h080);
      end
    end

    // OP-IMM funct3 000 ignores funct7_5.
    @(negedge clk); rand_data(); set_instr(7'h13, 3'd0, 1'b1);
    cycle("opimm_add");
    chk("opimm_add_code", 32'(ex_alu_ctrl), 32'h001);
    chk("opimm_b_imm", ex_b, id_imm);

    // AUIPC operands.
    @(negedge clk); rand_data(); id_pc = 32'h100; id_imm = 32'h1000; set_instr(7'h17, 3'd0, 1'b0);
    cycle("auipc");
    chk("auipc_a", ex_a, 32'h100);
    chk("auipc_b", ex_b, 32'h1000);
    chk("auipc_code", 32'(ex_alu_ctrl), 32'h001);

    // LUI zeroes operand A.
    @(negedge clk); rand_data(); id_rs1_data = 32'hFFFF_FFFF; set_instr(7'h37, 3'd0, 1'b0);
    cycle("lui");
    chk("lui_a", ex_a, 32'd0);

    // Stall for three cycles while ID changes, then flush under stall.
    @(negedge clk); rand_data(); set_instr(7'h33, 3'd7, 1'b0);
    cycle("pre_stall");
    saved = exp_ex;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); stall = 1'b1; rand_data(); set_instr(op_list[$urandom_range(0, 9)], 3'($urandom), 1'($urandom));
      cycle("stall_hold");
      chk("stall_pc", ex_pc, saved.pc);
      chk("stall_code", 32'(ex_alu_ctrl), 32'h200);
    end
    @(negedge clk); flush = 1'b1;
    cycle("flush_under_stall");
    chk("flush_valid", 32'(ex_valid), 32'd0);
    @(negedge clk); flush = 1'b0;
    cycle("bubble_stalled");
    @(negedge clk); stall = 1'b0;

    // Illegal opcode is captured as a valid, non-writing slot.
    rand_data(); set_instr(7'h7F, 3'd0, 1'b0);
    cycle("illegal");
    chk("illegal_flag", 32'(ex_illegal), 32'd1);
    chk("illegal_valid", 32'(ex_valid), 32'd1);
    chk("illegal_rw", 32'(ex_reg_write), 32'd0);

    // Branch funct3 010 is illegal.
    @(negedge clk); rand_data(); set_instr(7'h63, 3'd2, 1'b0);
    cycle("branch_illegal");

    // Writes to x0 are suppressed.
    @(negedge clk); rand_data(); id_rd_addr = 5'd0; set_instr(7'h33, 3'd0, 1'b0);
    cycle("rd_zero");
    chk("rd_zero_rw", 32'(ex_reg_write), 32'd0);

    // Reset during a stall clears the slot; normal capture resumes afterwards.
    @(negedge clk); rand_data(); set_instr(7'h6F, 3'd0, 1'b0);
    cycle("pre_rst_stall");
    @(negedge clk); stall = 1'b1; #1; rst = 1'b1; #1;
    exp_ex = '0;
    check_all("rst_in_stall");
    @(negedge clk); rst = 1'b0; stall = 1'b0; rand_data(); set_instr(7'h03, 3'd2, 1'b0);
    cycle("after_rst_stall");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rand_data();
      if ($urandom_range(0, 7) == 0) id_rd_addr = 5'd0;
      if ($urandom_range(0, 9) == 0)
        set_instr(7'($urandom), 3'($urandom), 1'($urandom));
      else
        set_instr(op_list[$urandom_range(0, 9)], 3'($urandom), 1'($urandom));
      id_valid = ($urandom_range(0, 5) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
